// File: rtl/temporizador_pkg.sv
// rtl/temporizador_pkg.sv - shared types and constants for the countdown irrigation timer
package temporizador_pkg;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONTANDO = 2'd1,
      PAUSADO  = 2'd2,
      FIM      = 2'd3
   } estado_t;

   typedef logic [3:0] bcd_t;

   // MM:SS as four BCD digits, most significant first
   typedef struct packed {
      bcd_t dm;
      bcd_t um;
      bcd_t ds;
      bcd_t us;
   } tempo_t;

   localparam int LIMITE_SEGUNDOS = 59;
   localparam int DIGITO_MAX      = 9;
   localparam int DEZENA_MAX      = 5;

   function automatic logic tempo_zerado(input tempo_t t);
      return (t == '0);
   endfunction

endpackage

// File: rtl/binario_para_bcd.sv
// rtl/binario_para_bcd.sv - clamps a 6-bit binary field to LIMITE and splits it into BCD tens/units
module binario_para_bcd
   import temporizador_pkg::*;
#(
   parameter int LIMITE = LIMITE_SEGUNDOS
) (
   input  logic [5:0] binario,
   output logic [3:0] dezena,
   output logic [3:0] unidade
);

   logic [5:0] limitado;

   always_comb begin
      limitado = (binario > 6'(LIMITE)) ? 6'(LIMITE) : binario;
      dezena   = 4'(limitado / 6'd10);
      unidade  = 4'(limitado % 6'd10);
   end

endmodule

// File: rtl/temporizador_regressivo.sv
// rtl/temporizador_regressivo.sv - MM:SS countdown timer with pause, abort and end-of-cycle pulse
// Optional periodic reload of the last loaded value: define TEMPORIZADOR_RECARGA_EN
module temporizador_regressivo
   import temporizador_pkg::*;
#(
   parameter int MAX_MINUTOS  = 59,
   parameter int MAX_SEGUNDOS = 59
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic       umSegundo,
   input  logic       carregar,
   input  logic [5:0] minutosCarga,
   input  logic [5:0] segundosCarga,
   input  logic       pausar,
   input  logic       cancelar,
   output logic [3:0] dezenaMinuto,
   output logic [3:0] unidadeMinuto,
   output logic [3:0] dezenaSegundos,
   output logic [3:0] unidadeSegundos,
   output logic       ativo,
   output logic       fimPulso
);

   estado_t estado_q, estado_d;
   tempo_t  tempo_q, tempo_d;
   tempo_t  tempo_carga, tempo_dec;
   logic    ativo_q, ativo_d;
   logic    fim_q, fim_d;
   bcd_t    carga_dm, carga_um, carga_ds, carga_us;

`ifdef TEMPORIZADOR_RECARGA_EN
   tempo_t  retido_q, retido_d;
`endif

   binario_para_bcd #(.LIMITE(MAX_MINUTOS)) u_minutos (
      .binario (minutosCarga),
      .dezena  (carga_dm),
      .unidade (carga_um)
   );

   binario_para_bcd #(.LIMITE(MAX_SEGUNDOS)) u_segundos (
      .binario (segundosCarga),
      .dezena  (carga_ds),
      .unidade (carga_us)
   );

   always_comb begin
      tempo_carga = '{dm: carga_dm, um: carga_um, ds: carga_ds, us: carga_us};
   end

   // Borrow chain; 00:00 is held rather than wrapped
   always_comb begin
      tempo_dec = tempo_q;
      if (!tempo_zerado(tempo_q)) begin
         if (tempo_q.us != 4'd0) begin
            tempo_dec.us = tempo_q.us - 4'd1;
         end else begin
            tempo_dec.us = 4'(DIGITO_MAX);
            if (tempo_q.ds != 4'd0) begin
               tempo_dec.ds = tempo_q.ds - 4'd1;
            end else begin
               tempo_dec.ds = 4'(DEZENA_MAX);
               if (tempo_q.um != 4'd0) begin
                  tempo_dec.um = tempo_q.um - 4'd1;
               end else begin
                  tempo_dec.um = 4'(DIGITO_MAX);
                  if (tempo_q.dm != 4'd0) begin
                     tempo_dec.dm = tempo_q.dm - 4'd1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      estado_d = estado_q;
      tempo_d  = tempo_q;
`ifdef TEMPORIZADOR_RECARGA_EN
      retido_d = retido_q;
`endif
      if (cancelar) begin
         estado_d = OCIOSO;
         tempo_d  = '0;
`ifdef TEMPORIZADOR_RECARGA_EN
         retido_d = '0;
`endif
      end else if (carregar) begin
         tempo_d = tempo_carga;
         if (tempo_zerado(tempo_carga)) begin
            estado_d = OCIOSO;
         end else begin
            estado_d = pausar ? PAUSADO : CONTANDO;
`ifdef TEMPORIZADOR_RECARGA_EN
            retido_d = tempo_carga;
`endif
         end
      end else begin
         unique case (estado_q)
            CONTANDO: begin
               if (pausar) begin
                  estado_d = PAUSADO;
               end else if (umSegundo) begin
                  tempo_d = tempo_dec;
                  if (tempo_zerado(tempo_dec)) begin
                     estado_d = FIM;
                  end
               end
            end
            PAUSADO: begin
               if (!pausar) begin
                  estado_d = CONTANDO;
               end
            end
            FIM: begin
               tempo_d  = '0;
               estado_d = OCIOSO;
`ifdef TEMPORIZADOR_RECARGA_EN
               if (!tempo_zerado(retido_q)) begin
                  tempo_d  = retido_q;
                  estado_d = pausar ? PAUSADO : CONTANDO;
               end
`endif
            end
            default: begin
               estado_d = OCIOSO;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they appear registered alongside it
   always_comb begin
      ativo_d = (estado_d == CONTANDO) || (estado_d == PAUSADO);
      fim_d   = (estado_d == FIM);
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         estado_q <= OCIOSO;
         tempo_q  <= '0;
         ativo_q  <= 1'b0;
         fim_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         tempo_q  <= tempo_d;
         ativo_q  <= ativo_d;
         fim_q    <= fim_d;
      end
   end

`ifdef TEMPORIZADOR_RECARGA_EN
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         retido_q <= '0;
      end else begin
         retido_q <= retido_d;
      end
   end
`endif

   assign dezenaMinuto    = tempo_q.dm;
   assign unidadeMinuto   = tempo_q.um;
   assign dezenaSegundos  = tempo_q.ds;
   assign unidadeSegundos = tempo_q.us;
   assign ativo           = ativo_q;
   assign fimPulso        = fim_q;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// tb/tb_temporizador_regressivo.sv - self-checking bench for temporizador_regressivo
module tb_temporizador_regressivo;

   logic       clock = 1'b0;
   logic       resetN = 1'b0;
   logic       umSegundo = 1'b0;
   logic       carregar = 1'b0;
   logic [5:0] minutosCarga = '0;
   logic [5:0] segundosCarga = '0;
   logic       pausar = 1'b0;
   logic       cancelar = 1'b0;
   logic [3:0] dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos;
   logic       ativo, fimPulso;
   logic [15:0] digitos;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   temporizador_regressivo dut (
      .clock           (clock),
      .resetN          (resetN),
      .umSegundo       (umSegundo),
      .carregar        (carregar),
      .minutosCarga    (minutosCarga),
      .segundosCarga   (segundosCarga),
      .pausar          (pausar),
      .cancelar        (cancelar),
      .dezenaMinuto    (dezenaMinuto),
      .unidadeMinuto   (unidadeMinuto),
      .dezenaSegundos  (dezenaSegundos),
      .unidadeSegundos (unidadeSegundos),
      .ativo           (ativo),
      .fimPulso        (fimPulso)
   );

   always #5 clock = ~clock;

   assign digitos = {dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos};

   // Model: remaining time kept as plain seconds, mode as a small integer
   localparam int M_OCIOSO = 0;
   localparam int M_CONTA  = 1;
   localparam int M_PAUSA  = 2;
   localparam int M_FIM    = 3;

   int m_modo = M_OCIOSO;
   int m_resto = 0;
   int m_retido = 0;

   function automatic int limita(input logic [5:0] v);
      return (int'(v) > 59) ? 59 : int'(v);
   endfunction

   function automatic logic [15:0] para_bcd(input int total);
      int mm;
      int ss;
      mm = total / 60;
      ss = total % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   always @(posedge clock or negedge resetN) begin
      int v;
      if (!resetN) begin
         m_modo <= M_OCIOSO;
         m_resto <= 0;
         m_retido <= 0;
      end else if (cancelar) begin
         m_modo <= M_OCIOSO;
         m_resto <= 0;
         m_retido <= 0;
      end else if (carregar) begin
         v = limita(minutosCarga) * 60 + limita(segundosCarga);
         m_resto <= v;
         if (v == 0) begin
            m_modo <= M_OCIOSO;
         end else begin
            m_retido <= v;
            m_modo <= pausar ? M_PAUSA : M_CONTA;
         end
      end else if (m_modo == M_CONTA) begin
         if (pausar) begin
            m_modo <= M_PAUSA;
         end else if (umSegundo) begin
            m_resto <= m_resto - 1;
            if (m_resto == 1) m_modo <= M_FIM;
         end
      end else if (m_modo == M_PAUSA) begin
         if (!pausar) m_modo <= M_CONTA;
      end else if (m_modo == M_FIM) begin
         m_modo <= M_OCIOSO;
`ifdef TEMPORIZADOR_RECARGA_EN
         if (m_retido != 0) begin
            m_resto <= m_retido;
            m_modo <= pausar ? M_PAUSA : M_CONTA;
         end
`endif
      end
   end

   task automatic chk(input string nome, input logic [15:0] actual, input logic [15:0] esperado);
      checks++;
      if (actual !== esperado) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nome, actual, esperado, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("model_digits", digitos, para_bcd(m_resto));
         chk("model_ativo", {15'd0, ativo},
             {15'd0, (m_modo == M_CONTA) || (m_modo == M_PAUSA)});
         chk("model_fim", {15'd0, fimPulso}, {15'd0, m_modo == M_FIM});
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic carga(input logic [5:0] m, input logic [5:0] s);
      minutosCarga = m;
      segundosCarga = s;
      carregar = 1'b1;
      cyc();
      carregar = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         umSegundo = 1'b1;
         cyc();
         umSegundo = 1'b0;
         cyc();
      end
   endtask

   initial begin
      repeat (2) cyc();
      chk("reset_digits", digitos, 16'h0000);
      chk("reset_ativo", {15'd0, ativo}, 16'd0);
      chk("reset_fim", {15'd0, fimPulso}, 16'd0);
      resetN = 1'b1;
      chk_en = 1'b1;
      cyc();

      carga(6'd1, 6'd0);
      chk("load_0100", digitos, 16'h0100);
      chk("load_ativo", {15'd0, ativo}, 16'd1);
      ticks(1);
      chk("tick_0059", digitos, 16'h0059);
      ticks(58);
      chk("tick_0001", digitos, 16'h0001);
      umSegundo = 1'b1;
      cyc();
      umSegundo = 1'b0;
      chk("end_fim_high", {15'd0, fimPulso}, 16'd1);
      chk("end_digits", digitos, 16'h0000);
      chk("end_ativo_low", {15'd0, ativo}, 16'd0);
      cyc();
      chk("end_fim_once", {15'd0, fimPulso}, 16'd0);
      ticks(2);
      chk("idle_holds", digitos, 16'h0000);

      carga(6'd10, 6'd0);
      ticks(1);
      chk("borrow_0959", digitos, 16'h0959);
      carga(6'd0, 6'd10);
      chk("load_0010", digitos, 16'h0010);
      ticks(1);
      chk("borrow_0009", digitos, 16'h0009);

      carga(6'd63, 6'd60);
      chk("clamp_5959", digitos, 16'h5959);
      carga(6'd0, 6'd0);
      chk("zero_digits", digitos, 16'h0000);
      chk("zero_ativo", {15'd0, ativo}, 16'd0);
      chk("zero_fim", {15'd0, fimPulso}, 16'd0);
      cyc();
      chk("zero_fim_later", {15'd0, fimPulso}, 16'd0);

      carga(6'd0, 6'd5);
      pausar = 1'b1;
      ticks(3);
      chk("pause_digits", digitos, 16'h0005);
      chk("pause_ativo", {15'd0, ativo}, 16'd1);
      pausar = 1'b0;
      cyc();
      ticks(1);
      chk("resume_0004", digitos, 16'h0004);

      cancelar = 1'b1;
      carregar = 1'b1;
      minutosCarga = 6'd3;
      segundosCarga = 6'd0;
      cyc();
      cancelar = 1'b0;
      carregar = 1'b0;
      chk("prio_digits", digitos, 16'h0000);
      chk("prio_ativo", {15'd0, ativo}, 16'd0);
      cyc();
      chk("prio_no_fim", {15'd0, fimPulso}, 16'd0);

      carga(6'd2, 6'd30);
      ticks(5);
      chk("pre_reset_0225", digitos, 16'h0225);
      #1 resetN = 1'b0;
      #1;
      chk("async_digits", digitos, 16'h0000);
      chk("async_ativo", {15'd0, ativo}, 16'd0);
      #1 resetN = 1'b1;
      cyc();

`ifdef TEMPORIZADOR_RECARGA_EN
      carga(6'd0, 6'd2);
      ticks(1);
      chk("rel_0001", digitos, 16'h0001);
      umSegundo = 1'b1;
      cyc();
      umSegundo = 1'b0;
      chk("rel_fim1", {15'd0, fimPulso}, 16'd1);
      cyc();
      chk("rel_reload", digitos, 16'h0002);
      chk("rel_ativo", {15'd0, ativo}, 16'd1);
      chk("rel_fim_low", {15'd0, fimPulso}, 16'd0);
      ticks(1);
      umSegundo = 1'b1;
      cyc();
      umSegundo = 1'b0;
      chk("rel_fim2", {15'd0, fimPulso}, 16'd1);
      cancelar = 1'b1;
      cyc();
      cancelar = 1'b0;
      ticks(3);
      chk("rel_cancel", {15'd0, ativo}, 16'd0);
`endif

      repeat (3) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
